// File: rtl/rr_stream_mux.sv
// rr_stream_mux: NCH-channel valid/ready stream mux with round-robin grant and a registered output stage.
// Define RR_STREAM_MUX_FIXED_SEL_EN to replace round-robin with an external sel input.
module rr_stream_mux #(
  parameter int NCH = 16,
  parameter int WIDTH = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef RR_STREAM_MUX_FIXED_SEL_EN
  ,
  input  logic [SELW-1:0]      sel
`endif
);
  logic [SELW-1:0] g;
  logic any;
  logic load;
`ifdef RR_STREAM_MUX_FIXED_SEL_EN
  always_comb begin
    g = sel;
    any = (int'(sel) < NCH) && in_valid[sel];
  end
`else
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] idx;
  // Scan from farthest to nearest so the nearest valid channel after ptr wins.
  always_comb begin
    g = '0;
    any = 1'b0;
    idx = '0;
    for (int i = NCH; i >= 1; i--) begin
      idx = SELW'((int'(ptr) + i) % NCH);
      if (in_valid[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= SELW'(NCH - 1);
    else if (load) ptr <= g;
  end
`endif
  assign load = !rst && (!out_valid || out_ready) && any;
  assign in_ready = load ? (NCH'(1) << g) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= in_data[g*WIDTH +: WIDTH];
      out_ch <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
